// File: rtl/ram_fifo_ctrl.sv
// FIFO controller sequencing a single-port RAM whose read address is registered inside the RAM.
// Each request is granted as one RAM operation; contending write/read requests alternate.
module ram_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 256,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wr_req,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ack,
    input  logic                  i_rd_req,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [AW:0]           o_count,
    output logic                  o_ram_wren,
    output logic [AW-1:0]         o_ram_address,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    input  logic [DATA_WIDTH-1:0] i_ram_q
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_WR_ACK  = 3'd2,
        S_READ    = 3'd3,
        S_RD_WAIT = 3'd4,
        S_RD_ACK  = 3'd5
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    state_t                r_state;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  r_last_wr;
    logic                  r_wr_ack;
    logic                  r_rd_valid;
    logic                  r_ram_wren;
    logic [AW-1:0]         r_ram_address;
    logic [DATA_WIDTH-1:0] r_ram_data;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic w_full;
    logic w_empty;
    logic w_wr_elig;
    logic w_rd_elig;
    logic w_grant_wr;
    logic w_grant_rd;

    assign w_full    = (r_count == FULL_COUNT);
    assign w_empty   = (r_count == '0);
    assign w_wr_elig = i_wr_req & ~w_full;
    assign w_rd_elig = i_rd_req & ~w_empty;

    // On contention the side that did not win last time gets the RAM.
    assign w_grant_wr = w_wr_elig & (~w_rd_elig | ~r_last_wr);
    assign w_grant_rd = w_rd_elig & (~w_wr_elig |  r_last_wr);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_last_wr     <= 1'b0;
            r_wr_ack      <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_ram_wren    <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_rd_data     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_wr) begin
                        r_state       <= S_WRITE;
                        r_ram_wren    <= 1'b1;
                        r_ram_address <= r_wr_ptr;
                        r_ram_data    <= i_wr_data;
                        r_last_wr     <= 1'b1;
                    end else if (w_grant_rd) begin
                        r_state       <= S_READ;
                        r_ram_address <= r_rd_ptr;
                        r_last_wr     <= 1'b0;
                    end
                end
                S_WRITE: begin
                    r_state    <= S_WR_ACK;
                    r_ram_wren <= 1'b0;
                    r_wr_ack   <= 1'b1;
                    r_wr_ptr   <= r_wr_ptr + 1'b1;
                    r_count    <= r_count + 1'b1;
                end
                S_WR_ACK: begin
                    r_state  <= S_IDLE;
                    r_wr_ack <= 1'b0;
                end
                S_READ: begin
                    r_state  <= S_RD_WAIT;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_count  <= r_count - 1'b1;
                end
                // The RAM latched the address at the end of READ, so i_ram_q is valid here.
                S_RD_WAIT: begin
                    r_state    <= S_RD_ACK;
                    r_rd_data  <= i_ram_q;
                    r_rd_valid <= 1'b1;
                end
                S_RD_ACK: begin
                    r_state    <= S_IDLE;
                    r_rd_valid <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wr_ack   <= 1'b0;
                    r_rd_valid <= 1'b0;
                    r_ram_wren <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_ack      = r_wr_ack;
    assign o_rd_valid    = r_rd_valid;
    assign o_rd_data     = r_rd_data;
    assign o_count       = r_count;
    assign o_full        = w_full;
    assign o_empty       = w_empty;
    assign o_ram_wren    = r_ram_wren;
    assign o_ram_address = r_ram_address;
    assign o_ram_data    = r_ram_data;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: directed scenarios plus a random write/read walk,
// checked against a queue-based FIFO model and a behavioural address-registered RAM.
module tb_ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rstN;
    logic          wrReq;
    logic          rdReq;
    logic [DW-1:0] wrData;
    logic          wrAck;
    logic [DW-1:0] rdData;
    logic          rdValid;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ramWren;
    logic [AW-1:0] ramAddress;
    logic [DW-1:0] ramData;
    logic [DW-1:0] ramQ;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ramAddrQ;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] refQ [$];
    logic [AW-1:0] expWrPtr;
    logic [AW-1:0] expRdPtr;
    logic          lastWasWrite;

    int            n;
    int            events;
    logic          sawAck;
    logic          sawWren;
    logic          sawValid;
    logic          expectWrite;
    logic [AW-1:0] wa;
    logic [DW-1:0] expData;

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rstN),
        .i_wr_req      (wrReq),
        .i_wr_data     (wrData),
        .o_wr_ack      (wrAck),
        .i_rd_req      (rdReq),
        .o_rd_data     (rdData),
        .o_rd_valid    (rdValid),
        .o_full        (full),
        .o_empty       (empty),
        .o_count       (count),
        .o_ram_wren    (ramWren),
        .o_ram_address (ramAddress),
        .o_ram_data    (ramData),
        .i_ram_q       (ramQ)
    );

    // Single-port RAM that registers its address; contents survive controller reset.
    always @(posedge clk) begin
        if (ramWren) mem[ramAddress] <= ramData;
        ramAddrQ <= ramAddress;
    end
    assign ramQ = mem[ramAddrQ];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rd, input logic [DW-1:0] d);
        wrReq  = wr;
        rdReq  = rd;
        wrData = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        refQ.delete();
        expWrPtr     = '0;
        expRdPtr     = '0;
        lastWasWrite = 1'b0;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, '0);
        rstN = 1'b0;
        #7;
        @(negedge clk);
        rstN = 1'b1;
        tick();
        modelReset();
    endtask

    // Issue one write from idle and check the grant/ack timing and the RAM write it produces.
    task automatic writeWord(input logic [DW-1:0] d, input string tag);
        int            k;
        int            wrenCyc;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        k = 0; wrenCyc = 0; addr = '1; wd = ~d;
        applyStimulus(1'b1, 1'b0, d);
        do begin
            tick(); k++;
            if (ramWren) begin wrenCyc = k; addr = ramAddress; wd = ramData; end
        end while (!wrAck && k < 20);
        wrReq = 1'b0;
        refQ.push_back(d);
        checkOutput({tag, "Ack"}, wrAck, 1);
        checkOutput({tag, "AckLatency"}, k, 2);
        checkOutput({tag, "WrenCycle"}, wrenCyc, 1);
        checkOutput({tag, "Addr"}, addr, expWrPtr);
        checkOutput({tag, "Data"}, wd, d);
        checkOutput({tag, "Count"}, count, refQ.size());
        checkOutput({tag, "Empty"}, empty, 0);
        checkOutput({tag, "Full"}, full, refQ.size() == DEPTH);
        expWrPtr++;
        lastWasWrite = 1'b1;
        tick();
        checkOutput({tag, "AckPulse"}, wrAck, 0);
    endtask

    // Issue one read from idle and check address, latency, returned word and hold behaviour.
    task automatic readWord(input string tag);
        int            k;
        logic [AW-1:0] addr;
        logic          wrenSeen;
        logic [DW-1:0] want;
        k = 0; addr = '1; wrenSeen = 1'b0;
        applyStimulus(1'b0, 1'b1, wrData);
        do begin
            tick(); k++;
            if (k == 1) addr = ramAddress;
            if (ramWren) wrenSeen = 1'b1;
        end while (!rdValid && k < 20);
        rdReq = 1'b0;
        want = refQ.pop_front();
        checkOutput({tag, "Valid"}, rdValid, 1);
        checkOutput({tag, "ValidLatency"}, k, 3);
        checkOutput({tag, "Addr"}, addr, expRdPtr);
        checkOutput({tag, "NoWren"}, wrenSeen, 0);
        checkOutput({tag, "Data"}, rdData, want);
        checkOutput({tag, "Count"}, count, refQ.size());
        checkOutput({tag, "Empty"}, empty, refQ.size() == 0);
        expRdPtr++;
        lastWasWrite = 1'b0;
        tick();
        checkOutput({tag, "ValidPulse"}, rdValid, 0);
        checkOutput({tag, "DataHold"}, rdData, want);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values while reset is held
        rstN = 1'b0;
        applyStimulus(1'b0, 1'b0, '0);
        #23;
        checkOutput("rstWrAck", wrAck, 0);
        checkOutput("rstRdValid", rdValid, 0);
        checkOutput("rstRamWren", ramWren, 0);
        checkOutput("rstRamAddress", ramAddress, 0);
        checkOutput("rstRamData", ramData, 0);
        checkOutput("rstRdData", rdData, 0);
        checkOutput("rstCount", count, 0);
        checkOutput("rstEmpty", empty, 1);
        checkOutput("rstFull", full, 0);
        @(negedge clk);
        rstN = 1'b1;
        tick();
        modelReset();

        // First write after reset
        writeWord(8'hA5, "firstWr");

        // Two writes then two reads in order
        doReset();
        writeWord(8'h11, "seqWr0");
        writeWord(8'h22, "seqWr1");
        readWord("seqRd0");
        readWord("seqRd1");

        // Fill to capacity, stall a write until a read frees space, then wrap to address 0
        doReset();
        for (int i = 0; i < DEPTH; i++) writeWord(8'(i), "fill");
        checkOutput("fullFlag", full, 1);
        checkOutput("fullCount", count, DEPTH);
        applyStimulus(1'b1, 1'b0, 8'h5A);
        sawAck = 1'b0; sawWren = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wrAck) sawAck = 1'b1;
            if (ramWren) sawWren = 1'b1;
        end
        checkOutput("stallNoAck", sawAck, 0);
        checkOutput("stallNoWren", sawWren, 0);
        rdReq = 1'b1; n = 0;
        do begin
            tick(); n++;
            if (ramWren) sawWren = 1'b1;
        end while (!rdValid && n < 20);
        rdReq = 1'b0;
        expData = refQ.pop_front();
        expRdPtr++;
        lastWasWrite = 1'b0;
        checkOutput("stallRdValid", rdValid, 1);
        checkOutput("stallRdData", rdData, expData);
        checkOutput("stallNoWrenDuringRead", sawWren, 0);
        n = 0; wa = '1;
        do begin
            tick(); n++;
            if (ramWren) wa = ramAddress;
        end while (!wrAck && n < 20);
        wrReq = 1'b0;
        refQ.push_back(8'h5A);
        checkOutput("wrapAck", wrAck, 1);
        checkOutput("wrapAddr", wa, expWrPtr);
        expWrPtr++;
        lastWasWrite = 1'b1;
        checkOutput("wrapCount", count, refQ.size());
        tick();

        // Contending requests alternate, starting opposite to the previous grant
        doReset();
        writeWord(8'($urandom), "altPreW0");
        writeWord(8'($urandom), "altPreW1");
        writeWord(8'($urandom), "altPreW2");
        readWord("altPreR");
        expectWrite = ~lastWasWrite;
        applyStimulus(1'b1, 1'b1, 8'($urandom));
        events = 0; n = 0;
        while (events < 4 && n < 80) begin
            tick(); n++;
            if (wrAck || rdValid) begin
                checkOutput($sformatf("altOrder%0d", events), wrAck, expectWrite);
                checkOutput($sformatf("altSingleOp%0d", events), wrAck & rdValid, 0);
                if (wrAck) begin
                    refQ.push_back(wrData);
                    expWrPtr++;
                    lastWasWrite = 1'b1;
                    wrData = 8'($urandom);
                end else begin
                    expData = (refQ.size() != 0) ? refQ.pop_front() : 'x;
                    checkOutput($sformatf("altRdData%0d", events), rdData, expData);
                    expRdPtr++;
                    lastWasWrite = 1'b0;
                end
                expectWrite = ~expectWrite;
                events++;
            end
        end
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("altEvents", events, 4);
        checkOutput("altCount", count, refQ.size());
        tick(); tick();

        // Read while empty stalls; a later write is serviced and then read back
        doReset();
        applyStimulus(1'b0, 1'b1, '0);
        sawWren = 1'b0; sawValid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rdValid) sawValid = 1'b1;
            if (ramWren) sawWren = 1'b1;
        end
        checkOutput("emptyNoValid", sawValid, 0);
        checkOutput("emptyNoWren", sawWren, 0);
        wrData = 8'($urandom);
        wrReq = 1'b1; n = 0;
        while (!rdValid && n < 40) begin
            tick(); n++;
            if (wrAck) begin
                wrReq = 1'b0;
                refQ.push_back(wrData);
                expWrPtr++;
                lastWasWrite = 1'b1;
            end
        end
        rdReq = 1'b0;
        expData = (refQ.size() != 0) ? refQ.pop_front() : 'x;
        checkOutput("emptyLaterValid", rdValid, 1);
        checkOutput("emptyLaterData", rdData, expData);
        checkOutput("emptyLaterCount", count, refQ.size());
        checkOutput("emptyLaterEmpty", empty, 1);
        expRdPtr++;
        lastWasWrite = 1'b0;
        tick(); tick();

        // Reset during the RAM wait cycle of a read aborts it
        doReset();
        writeWord(8'($urandom), "abortPreW");
        applyStimulus(1'b0, 1'b1, '0);
        tick(); tick();
        #2 rstN = 1'b0;
        #1 rdReq = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        modelReset();
        sawValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (rdValid) sawValid = 1'b1;
        end
        checkOutput("abortNoValid", sawValid, 0);
        checkOutput("abortCount", count, 0);
        checkOutput("abortEmpty", empty, 1);
        writeWord(8'($urandom), "abortPostW");

        // Random walk of writes and reads against the queue model
        doReset();
        for (int i = 0; i < 150; i++) begin
            if (refQ.size() == 0 || (refQ.size() < DEPTH && $urandom_range(0, 1) == 1))
                writeWord(8'($urandom), "rndW");
            else
                readWord("rndR");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width.
REQ-002 Parameter DEPTH, default 256, SHALL set the RAM depth; it SHALL be a power of two. AW = log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_req  input  1  write request, held until wr_ack.
REQ-006 wr_data  input  DATA_WIDTH  write word, stable while wr_req is high.
REQ-007 wr_ack  output  1  one-cycle pulse: write accepted and committed.
REQ-008 rd_req  input  1  read request, held until rd_valid.
REQ-009 rd_data  output  DATA_WIDTH  read word, valid while rd_valid is high.
REQ-010 rd_valid  output  1  one-cycle pulse: rd_data valid.
REQ-011 full  output  1  count == DEPTH.
REQ-012 empty  output  1  count == 0.
REQ-013 count  output  AW+1  stored words.
REQ-014 ram_wren  output  1  to RAM write enable.
REQ-015 ram_address  output  AW  to RAM address.
REQ-016 ram_data  output  DATA_WIDTH  to RAM write data.
REQ-017 ram_q  input  DATA_WIDTH  from RAM; valid in the cycle after an address is presented (RAM registers the address).

Function
REQ-018 The block SHALL drive a single-port RAM as a FIFO, issuing at most one RAM operation per cycle.
REQ-019 FSM states SHALL be IDLE, WRITE, WR_ACK, READ, RD_WAIT and RD_ACK; all outputs except full/empty SHALL be registered.
REQ-020 IDLE: write eligible = wr_req & ~full; read eligible = rd_req & ~empty; if only one is eligible, go to WRITE or READ accordingly; otherwise stay in IDLE.
REQ-021 Both eligible: grant the opposite of the last grant; the first grant after reset SHALL be a write.
REQ-022 WRITE (1 cycle): ram_wren=1, ram_address=wr_ptr, ram_data=wr_data sampled at grant; at the cycle end wr_ptr+1 and count+1; go to WR_ACK.
REQ-023 WR_ACK (1 cycle): wr_ack=1, ram_wren=0; wr_req and rd_req SHALL be ignored; go to IDLE.
REQ-024 READ (1 cycle): ram_wren=0, ram_address=rd_ptr; at the cycle end rd_ptr+1 and count-1; go to RD_WAIT.
REQ-025 RD_WAIT (1 cycle): ram_address held; rd_data SHALL capture ram_q at the cycle end; go to RD_ACK.
REQ-026 RD_ACK (1 cycle): rd_valid=1; requests ignored; go to IDLE; rd_data SHALL hold its value until the next read capture.
REQ-027 Latency from the request-sampling edge: wr_ack SHALL be high 2 cycles later; rd_valid SHALL be high 3 cycles later.
REQ-028 Back-to-back throughput: one write per 3 cycles; one read per 4 cycles.
REQ-029 Pointers are AW bits and SHALL wrap from DEPTH-1 to 0 with no other action.
REQ-030 wr_req while full SHALL stall with no ack and no RAM write until a read frees space; rd_req while empty SHALL stall with no rd_valid.
REQ-031 count SHALL never exceed DEPTH or go below 0; full and empty SHALL be combinational from count.
REQ-032 ram_wren SHALL be 0 in every state except WRITE.

Reset
REQ-033 While rst_n=0: state=IDLE; wr_ptr, rd_ptr and count = 0; wr_ack, rd_valid and ram_wren = 0; ram_address, ram_data and rd_data = 0; empty=1; full=0; last grant = read (so the first grant is a write).
REQ-034 Reset asserted mid-operation SHALL abort immediately: no ack or valid for the in-flight request, a write in progress is not completed, and RAM contents are not cleared.

Verification
REQ-035 Reset, then wr_req with wr_data=8'hA5 -> ram_wren=1 with ram_address=0 one cycle after sampling; wr_ack pulse the next cycle; count=1; empty=0.
REQ-036 Write 8'h11, 8'h22, then rd_req twice -> rd_data=8'h11 then 8'h22, each rd_valid 3 cycles after sampling; count=0; empty=1.
REQ-037 Write 256 words (0..255) -> full=1, count=256; a 257th wr_req gets no ack until one read completes, then writes at address 0 (wrap).
REQ-038 Count=2 with wr_req and rd_req held together -> grants alternate W,R,W,R starting with the write; no cycle has two RAM operations.
REQ-039 rd_req while empty -> no rd_valid and ram_wren=0; a later wr_req is serviced and the read then returns that word.
REQ-040 rst_n pulsed low during RD_WAIT -> no rd_valid; count=0; empty=1; the next write uses address 0.
